alu_issue: RTL and testbench

//  Producer side of the ALU interface: accepts one 32-bit RV32I OP/OP-IMM instruction per

---
 rtl/riscv_pkg.sv | 19 +
 rtl/regfile.sv | 22 ++
 rtl/alu_issue.sv | 101 ++++++++++
 tb/tb_alu_issue.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I OP/OP-IMM encodings and issue-stage state type
package riscv_pkg;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;
    typedef enum logic [1:0] {IDLE, EXEC, WB, ILL} state_t;
    function automatic logic is_shift(input logic [2:0] f3);
        return f3 == F3_SLL || f3 == F3_SRL;
    endfunction
endpackage

// File: rtl/regfile.sv
// regfile: 32x32 registers, two operand reads, one debug read, one write, x0 fixed at zero
module regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  dra,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] drd,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] regs [32];
    always_ff @(posedge clk)
        if (rst) regs <= '{default: '0};
        else if (we && wa != 5'd0) regs[wa] <= wd;
    assign rd1 = ra1 == 5'd0 ? '0 : regs[ra1];
    assign rd2 = ra2 == 5'd0 ? '0 : regs[ra2];
    assign drd = dra == 5'd0 ? '0 : regs[dra];
endmodule

// File: rtl/alu_issue.sv
// alu_issue: serialised decode/issue to the ALU and writeback into the register file
module alu_issue
    import riscv_pkg::*;
#(
    parameter int ALU_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [31:0] alu_rs1,
    output logic [31:0] alu_rs2,
    output logic [2:0]  alu_funct3,
    output logic [6:0]  alu_funct7,
    input  logic [31:0] alu_rd,
    input  logic        alu_z,
    output logic        retire_valid,
    output logic [4:0]  retire_rd_addr,
    output logic [31:0] retire_data,
    output logic        retire_z,
    output logic        illegal,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata
);
    localparam int CW = ALU_LATENCY > 1 ? $clog2(ALU_LATENCY) : 1;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [4:0] rd_q;
    logic [31:0] rs1_data, rs2_data, dec_rs2;
    logic [6:0] opc, f7, dec_f7;
    logic [2:0] f3;
    logic legal;
    assign opc = instr[6:0];
    assign f3 = instr[14:12];
    assign f7 = instr[31:25];
    assign instr_ready = state == IDLE;
    assign illegal = state == ILL;
    regfile u_rf (
        .clk(clk), .rst(rst),
        .ra1(instr[19:15]), .ra2(instr[24:20]), .dra(dbg_raddr),
        .rd1(rs1_data), .rd2(rs2_data), .drd(dbg_rdata),
        .we(state == WB), .wa(rd_q), .wd(alu_rd)
    );
    always_comb begin
        dec_rs2 = rs2_data;
        dec_f7 = f7;
        legal = 1'b0;
        if (opc == OPC_OP)
            legal = f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SRL));
        else if (opc == OPC_OP_IMM && is_shift(f3)) begin
            dec_rs2 = {27'b0, instr[24:20]};
            legal = f7 == F7_BASE || (f7 == F7_ALT && f3 == F3_SRL);
        end else if (opc == OPC_OP_IMM) begin
            // funct7 forced to base so an immediate with bit 30 set never turns ADDI into SUB
            dec_rs2 = {{20{instr[31]}}, instr[31:20]};
            dec_f7 = F7_BASE;
            legal = 1'b1;
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (instr_valid) state_nx = legal ? EXEC : ILL;
            EXEC:    if (cnt == CW'(ALU_LATENCY - 1)) state_nx = WB;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_rs1 <= '0;
            alu_rs2 <= '0;
            alu_funct3 <= '0;
            alu_funct7 <= '0;
            rd_q <= '0;
            cnt <= '0;
            retire_valid <= 1'b0;
            retire_rd_addr <= '0;
            retire_data <= '0;
            retire_z <= 1'b0;
        end else begin
            retire_valid <= state == WB;
            if (state == IDLE && instr_valid && legal) begin
                alu_rs1 <= rs1_data;
                alu_rs2 <= dec_rs2;
                alu_funct3 <= f3;
                alu_funct7 <= dec_f7;
                rd_q <= instr[11:7];
                cnt <= '0;
            end
            if (state == EXEC) cnt <= cnt + 1'b1;
            if (state == WB) begin
                retire_rd_addr <= rd_q;
                retire_data <= alu_rd;
                retire_z <= alu_z;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed vectors into alu_issue with a behavioural ALU and a retire scoreboard
module tb_alu_issue;
    localparam int L = 1;
    logic clk = 1'b0, rst = 1'b1, instr_valid = 1'b0, instr_ready;
    logic [31:0] instr = '0, alu_rs1, alu_rs2, alu_rd, retire_data, dbg_rdata;
    logic [2:0] alu_funct3;
    logic [6:0] alu_funct7;
    logic alu_z, retire_valid, retire_z, illegal;
    logic [4:0] retire_rd_addr, dbg_raddr = '0;
    int errors = 0, checks = 0, cyc = 0, accepts = 0;
    typedef struct {bit ill; logic [4:0] rd; logic [31:0] data; int cyc;} exp_t;
    exp_t q[$];
    exp_t e;

    alu_issue #(.ALU_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
        .alu_rd(alu_rd), .alu_z(alu_z), .retire_valid(retire_valid), .retire_rd_addr(retire_rd_addr),
        .retire_data(retire_data), .retire_z(retire_z), .illegal(illegal),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        case (alu_funct3)
            3'b000:  alu_rd = alu_funct7[5] ? alu_rs1 - alu_rs2 : alu_rs1 + alu_rs2;
            3'b001:  alu_rd = alu_rs1 << alu_rs2[4:0];
            3'b010:  alu_rd = {31'b0, $signed(alu_rs1) < $signed(alu_rs2)};
            3'b011:  alu_rd = {31'b0, alu_rs1 < alu_rs2};
            3'b100:  alu_rd = alu_rs1 ^ alu_rs2;
            3'b101:  alu_rd = alu_funct7[5] ? 32'($signed(alu_rs1) >>> alu_rs2[4:0]) : alu_rs1 >> alu_rs2[4:0];
            3'b110:  alu_rd = alu_rs1 | alu_rs2;
            default: alu_rd = alu_rs1 & alu_rs2;
        endcase
    end
    assign alu_z = alu_rd == 32'd0;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, req);
        end
    endtask

    task automatic chk_reg(input logic [4:0] a, input logic [31:0] req);
        @(negedge clk);
        dbg_raddr = a;
        #1 chk($sformatf("dbg_x%0d", a), dbg_rdata, req);
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) chk("ready_timeout", 32'(instr_ready), 32'd1);
    endtask

    task automatic issue(input logic [31:0] w, input bit ill, input logic [4:0] rd, input logic [31:0] data, input int f7);
        wait_ready();
        instr = w;
        instr_valid = 1'b1;
        q.push_back('{ill, rd, data, cyc + 1});
        @(posedge clk);
        #1 instr_valid = 1'b0;
        if (!ill && f7 >= 0) chk("alu_funct7", 32'(alu_funct7), 32'(f7));
        wait_ready();
    endtask

    always @(negedge clk) begin
        if (!rst && (retire_valid || illegal)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output retire=%0b illegal=%0b expected none", retire_valid, illegal);
            end else begin
                e = q.pop_front();
                if (e.ill) begin
                    if (!illegal || retire_valid) begin
                        errors++;
                        $display("FAIL illegal_pulse illegal=%0b retire=%0b expected 1/0", illegal, retire_valid);
                    end
                end else if (!retire_valid || illegal || retire_rd_addr !== e.rd || retire_data !== e.data || cyc - e.cyc != L + 1) begin
                    errors++;
                    $display("FAIL retire got rd=%0d data=%h lat=%0d ill=%0b expected rd=%0d data=%h lat=%0d",
                             retire_rd_addr, retire_data, cyc - e.cyc, illegal, e.rd, e.data, L + 1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("reset_ready", 32'(instr_ready), 32'd1);
        chk("reset_retire", 32'(retire_valid), 32'd0);
        for (int i = 0; i < 32; i++) chk_reg(5'(i), 32'd0);

        issue(enc_i(12'd20, 5'd0, 3'b000, 5'd1), 0, 5'd1, 32'd20, 0);
        issue(enc_i(12'd30, 5'd0, 3'b000, 5'd2), 0, 5'd2, 32'd30, 0);
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 0, 5'd3, 32'd50, 0);
        chk_reg(5'd3, 32'd50);

        issue(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4), 0, 5'd4, 32'hFFFFFFF6, 32);
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd7), 0, 5'd7, 32'd1, 0);
        issue(enc_r(7'h00, 5'd1, 5'd2, 3'b011, 5'd8), 0, 5'd8, 32'd0, 0);

        issue(enc_i(12'hFFF, 5'd0, 3'b000, 5'd5), 0, 5'd5, 32'hFFFFFFFF, 0);
        issue(enc_i(12'h404, 5'd5, 3'b101, 5'd6), 0, 5'd6, 32'hFFFFFFFF, 32);
        issue(enc_i(12'h004, 5'd5, 3'b101, 5'd6), 0, 5'd6, 32'h0FFFFFFF, 0);

        issue(enc_i(12'd5, 5'd0, 3'b000, 5'd0), 0, 5'd0, 32'd5, 0);
        chk_reg(5'd0, 32'd0);
        issue(32'h00002003, 1, 5'd0, 32'd0, -1);
        issue(enc_r(7'h20, 5'd2, 5'd1, 3'b001, 5'd9), 1, 5'd0, 32'd0, -1);
        chk_reg(5'd1, 32'd20);
        chk_reg(5'd6, 32'h0FFFFFFF);
        chk_reg(5'd9, 32'd0);

        wait_ready();
        instr = enc_i(12'd1, 5'd9, 3'b000, 5'd9);
        instr_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (instr_ready) begin
                accepts++;
                q.push_back('{0, 5'd9, 32'(accepts), cyc + 1});
            end
            @(posedge clk);
            @(negedge clk);
        end
        instr_valid = 1'b0;
        chk("held_valid_accepts", 32'(accepts), 32'd4);
        wait_ready();
        chk_reg(5'd9, 32'd4);

        wait_ready();
        instr = enc_i(12'd7, 5'd0, 3'b000, 5'd10);
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(instr_ready), 32'd1);
        chk_reg(5'd10, 32'd0);
        chk_reg(5'd3, 32'd0);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
